// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Issue-side hazard tracker placed directly upstream of the integer register
//   file. Keeps a pending-write count per architectural register (x1..x31;
//   x0 is never tracked). It stalls issue on read-after-write hazards and when
//   a destination's count is already at its maximum. On issue it drives the
//   register file's read strobes and addresses, and it retires pending writes
//   from two writeback ports.
//
//   Build option: define RV_SB_MULTI_WR_EN to allow up to three in-flight
//   writes per register (2-bit counts). Without it, counts are 1 bit wide and
//   a destination with any pending write stalls issue.
//
// Ports
//   clk_i, reset_i           clock (rising edge), async active-high reset
//   clk_en_i                 state advances only when high
//   flush_i                  clears all pending-write tracking (err_o is kept)
//   issue_valid_i            instruction offered
//   issue_ready_o            instruction may issue (combinational)
//   issue_rs{1,2}_used_i/_i  source operand usage and indices
//   issue_rd_wr_i, issue_rd_i destination write flag and index
//   rreg_{a,b}_rd_o/_addr_o  register-file read strobes and addresses
//   wb_{a,b}_wr_i/_addr_i    writeback retire ports
//   pending_o                total outstanding writes, saturating at 63
//   err_o                    sticky underflow error, cleared only by reset
module regfile_scoreboard (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clk_en_i,
  input  logic       flush_i,
  input  logic       issue_valid_i,
  output logic       issue_ready_o,
  input  logic       issue_rs1_used_i,
  input  logic       issue_rs2_used_i,
  input  logic [4:0] issue_rs1_i,
  input  logic [4:0] issue_rs2_i,
  input  logic       issue_rd_wr_i,
  input  logic [4:0] issue_rd_i,
  output logic       rreg_a_rd_o,
  output logic       rreg_b_rd_o,
  output logic [4:0] rreg_a_addr_o,
  output logic [4:0] rreg_b_addr_o,
  input  logic       wb_a_wr_i,
  input  logic       wb_b_wr_i,
  input  logic [4:0] wb_a_addr_i,
  input  logic [4:0] wb_b_addr_i,
  output logic [5:0] pending_o,
  output logic       err_o
);

`ifdef RV_SB_MULTI_WR_EN
  localparam int unsigned CW = 2;
`else
  localparam int unsigned CW = 1;
`endif
  localparam logic [CW-1:0] CMAX = '1;

  // Entry 0 is reset to zero and only ever reloaded with zero, so x0 reads as
  // "no pending write" without any special-case indexing.
  logic [CW-1:0]      count_q   [32];
  logic [CW-1:0]      cnt_nxt   [32];
  logic [5:0]         pending_q;
  logic               err_q;

  logic               raw1;
  logic               raw2;
  logic               full;
  logic               fire;

  logic               inc;
  logic [2:0]         sum3;
  logic [2:0]         dec3;
  logic [2:0]         eff3;
  logic               err_set;
  logic signed [7:0]  pend_delta;
  logic signed [7:0]  pend_sum;
  logic [5:0]         pend_nxt;

  // Hazard detection. A writeback in the current cycle does not clear a
  // hazard until the count register updates.
  always_comb begin
    raw1          = issue_rs1_used_i & (count_q[issue_rs1_i] != '0);
    raw2          = issue_rs2_used_i & (count_q[issue_rs2_i] != '0);
    full          = issue_rd_wr_i & (issue_rd_i != 5'd0) & (count_q[issue_rd_i] == CMAX);
    issue_ready_o = ~raw1 & ~raw2 & ~full & ~flush_i;
    fire          = clk_en_i & issue_valid_i & issue_ready_o;
  end

  assign rreg_a_rd_o   = fire & issue_rs1_used_i;
  assign rreg_b_rd_o   = fire & issue_rs2_used_i;
  assign rreg_a_addr_o = issue_rs1_i;
  assign rreg_b_addr_o = issue_rs2_i;
  assign pending_o     = pending_q;
  assign err_o         = err_q;

  // Per-register net update. Retirements beyond what is outstanding clamp to
  // zero; only the retirements actually absorbed are subtracted from the
  // running total, so pending_o follows the sum of counts.
  always_comb begin
    cnt_nxt[0] = '0;
    inc        = 1'b0;
    sum3       = '0;
    dec3       = '0;
    eff3       = '0;
    err_set    = 1'b0;
    pend_delta = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      inc  = fire & issue_rd_wr_i & (issue_rd_i == 5'(r));
      dec3 = 3'(wb_a_wr_i & (wb_a_addr_i == 5'(r)))
           + 3'(wb_b_wr_i & (wb_b_addr_i == 5'(r)));
      sum3 = 3'(count_q[r]) + 3'(inc);
      if (dec3 > sum3) begin
        cnt_nxt[r] = '0;
        eff3       = sum3;
        err_set    = 1'b1;
      end else begin
        cnt_nxt[r] = CW'(sum3 - dec3);
        eff3       = dec3;
      end
      pend_delta = pend_delta + $signed({7'b0, inc}) - $signed({5'b0, eff3});
    end
    pend_sum = $signed({2'b00, pending_q}) + pend_delta;
    if (pend_sum < 0) begin
      pend_nxt = '0;
    end else if (pend_sum > 8'sd63) begin
      pend_nxt = '1;
    end else begin
      pend_nxt = pend_sum[5:0];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < 32; i++) begin
        count_q[i] <= '0;
      end
      pending_q <= '0;
      err_q     <= 1'b0;
    end else if (clk_en_i) begin
      if (flush_i) begin
        for (int unsigned i = 0; i < 32; i++) begin
          count_q[i] <= '0;
        end
        pending_q <= '0;
      end else begin
        count_q   <= cnt_nxt;
        pending_q <= pend_nxt;
        err_q     <= err_q | err_set;
      end
    end
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Issue-side hazard tracker that sits directly upstream of the integer register file. It holds a per-register pending-write count, accepts one instruction per cycle via a valid/ready handshake, stalls on read-after-write hazards against in-flight results, and drives the register file's two read strobes/addresses on issue. The two writeback ports mirror the register file's write ports and retire pending writes.

## Interface
- No parameters; width fixed at 32 architectural registers, x0 untracked.
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- clk_en_i  in  1  state advances only when high
- flush_i  in  1  discard all pending-write tracking
- issue_valid_i  in  1  instruction offered
- issue_ready_o  out  1  instruction may issue this cycle (combinational)
- issue_rs1_used_i, issue_rs2_used_i  in  1  source operand is read
- issue_rs1_i, issue_rs2_i  in  5  source register indices
- issue_rd_wr_i  in  1  instruction writes a destination
- issue_rd_i  in  5  destination index
- rreg_a_rd_o, rreg_b_rd_o  out  1  register-file read strobes (rs1 → a, rs2 → b)
- rreg_a_addr_o, rreg_b_addr_o  out  5  register-file read addresses
- wb_a_wr_i, wb_b_wr_i  in  1  result retired on writeback port a/b
- wb_a_addr_i, wb_b_addr_i  in  5  retired destination index
- pending_o  out  6  total outstanding writes, saturating at 63
- err_o  out  1  sticky: writeback to a register with zero pending count

## Operation
- State: count[1..31], each CW bits (see Configuration); count[0] is constant 0.
- fire = clk_en_i & issue_valid_i & issue_ready_o.
- raw1 = issue_rs1_used_i & (count[rs1] != 0); raw2 likewise for rs2.
- full = issue_rd_wr_i & (rd != 0) & (count[rd] == CMAX).
- issue_ready_o = ~raw1 & ~raw2 & ~full & ~flush_i. No bypass: a writeback in the same cycle does not clear a hazard until the next cycle.
- rreg_a_rd_o = fire & issue_rs1_used_i; rreg_a_addr_o = issue_rs1_i (passthrough). Port b likewise with rs2.
- Per register r ≠ 0, per enabled cycle: inc = fire & issue_rd_wr_i & (rd == r); dec = number of writeback ports (0–2) with wr & addr == r; next = count + inc − dec.
- Underflow: if dec exceeds count + inc, count clamps to 0 and err_o sets. Writebacks to x0 are ignored and never set err_o.
- Simultaneous inc and dec on the same register: net applied; count unchanged for 1/1.
- flush_i (with clk_en_i): all counts → 0, pending_o → 0; issue and writebacks in that cycle are ignored; err_o is kept.
- pending_o tracks the sum of counts by the same net inc/dec, clamped at 0 and 63.
- err_o clears only on reset.

## Timing
- Reset (asynchronous, immediate): all counts 0, pending_o 0, err_o 0. issue_ready_o is then a function of inputs only, so it reads 1 unless flush_i is high.
- issue_ready_o and the read strobes/addresses are combinational. Register-file read data appears one cycle after fire, because the register file reads synchronously.
- Count updates are visible on the cycle after the event.
- When clk_en_i is low, no state changes, and fire and the read strobes are 0.
- Reset asserted mid-stall drops all hazards; an instruction held valid issues in the first enabled cycle after reset releases.

## Configuration
- RV_SB_MULTI_WR_EN defined: CW = 2 and CMAX = 3. Up to three in-flight writes to the same register (WAW) are allowed before stalling.
- Not defined: CW = 1 and CMAX = 1. Issue stalls whenever the destination already has a pending write.

## Test plan
- Reset, then issue rd=5 with no sources. ready=1, and pending_o=1 next cycle. Then offer rs1=5 used: ready=0 until wb_a writes 5. Ready returns 1 the cycle after the writeback, not the same cycle.
- Issue rd=7 and retire wb_b addr 7 with count[7]=1 in the same cycle. count[7] stays 1 and pending_o is unchanged.
- With the macro defined, issue rd=3 four times: the first three fire, the fourth stalls. Without the macro, the second issue stalls.
- Retire wb_a addr 9 with count 0. err_o=1 and stays high through a flush; it clears only on reset_i.
- Both writeback ports retire address 4 with count[4]=2. count[4]=0 and pending_o drops by 2.
- Create 3 pending writes, assert flush_i for one cycle. pending_o=0, ready=1 for any sources. rd=0 issues never increment pending_o.
